// File: rtl/crc_stream_engine.sv
// Streaming MSB-first CRC engine: one DATA_W beat per clock over valid/ready,
// with beat counting, compare mode, abort and a held result handshake.
module crc_stream_engine #(
    parameter int                CRC_W  = 8,
    parameter logic [CRC_W-1:0]  POLY   = 'h07,
    parameter logic [CRC_W-1:0]  INIT   = '0,
    parameter logic [CRC_W-1:0]  XOROUT = '0,
    parameter int                DATA_W = 8,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              chk_en,
    input  logic [CRC_W-1:0]  ref_crc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic [CNT_W-1:0]  beat_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   res_q, res_d;
    logic               ok_q, ok_d;

    logic               accept;
    logic [CRC_W-1:0]   crc_fold;
    logic [CRC_W-1:0]   crc_fin;
    logic [CNT_W-1:0]   cnt_inc;

    function automatic logic [CRC_W-1:0] fold(
        input logic [CRC_W-1:0]  c,
        input logic [DATA_W-1:0] d
    );
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    // DONE blocks input so no beat of the next message slips in early
    assign in_ready  = rst_n && (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign crc_out   = res_q;
    assign crc_ok    = ok_q;
    assign beat_cnt  = cnt_q;

    assign accept   = in_valid && in_ready;
    assign crc_fold = fold(crc_q, in_data);
    assign crc_fin  = crc_fold ^ XOROUT;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ok_d    = ok_q;
        if (clr) begin
            state_d = IDLE;
            crc_d   = INIT;
            cnt_d   = '0;
            res_d   = '0;
            ok_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, RUN: begin
                    if (accept) begin
                        crc_d = crc_fold;
                        cnt_d = cnt_inc;
                        if (in_last) begin
                            state_d = DONE;
                            res_d   = crc_fin;
                            ok_d    = chk_en && (crc_fin == ref_crc);
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        crc_d   = INIT;
                        cnt_d   = '0;
                        res_d   = '0;
                        ok_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    crc_d   = INIT;
                    cnt_d   = '0;
                    res_d   = '0;
                    ok_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
            res_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ok_q    <= ok_d;
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: vector table on a CRC-8 instance
// plus handshake, abort, reset and CRC-16 width sequences.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // CRC-8 instance, small counter so saturation is reachable
    logic       in_valid = 0, in_last = 0, chk_en = 0, out_ready = 1;
    logic [7:0] in_data = 0, ref_crc = 0;
    logic       in_ready, out_valid, crc_ok;
    logic [7:0] crc_out;
    logic [3:0] beat_cnt;

    crc_stream_engine #(.CNT_W(4)) u8 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .chk_en(chk_en), .ref_crc(ref_crc),
        .out_valid(out_valid), .out_ready(out_ready),
        .crc_out(crc_out), .crc_ok(crc_ok), .beat_cnt(beat_cnt)
    );

    // CRC-16/CCITT-FALSE, 8-bit beats
    logic        a_valid = 0, a_last = 0, a_ready, a_ovalid, a_ok;
    logic [7:0]  a_data = 0;
    logic [15:0] a_crc;
    logic [15:0] a_cnt;

    crc_stream_engine #(
        .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF)
    ) u16 (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .in_last(a_last),
        .chk_en(1'b0), .ref_crc(16'h0),
        .out_valid(a_ovalid), .out_ready(1'b1),
        .crc_out(a_crc), .crc_ok(a_ok), .beat_cnt(a_cnt)
    );

    // Same CRC, 16-bit beats
    logic        b_valid = 0, b_last = 0, b_ready, b_ovalid, b_ok;
    logic [15:0] b_data = 0;
    logic [15:0] b_crc;
    logic [15:0] b_cnt;

    crc_stream_engine #(
        .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .DATA_W(16)
    ) u16w (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_last(b_last),
        .chk_en(1'b0), .ref_crc(16'h0),
        .out_valid(b_ovalid), .out_ready(1'b1),
        .crc_out(b_crc), .crc_ok(b_ok), .beat_cnt(b_cnt)
    );

    logic [7:0] msg [0:31];

    typedef struct {
        string       name;
        int          len;
        logic [31:0] bytes;
        logic        chk;
        logic [7:0]  rf;
        logic [7:0]  exp_crc;
        logic        exp_ok;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bit-serial reference over msg[0..n-1], MSB-first
    function automatic logic [15:0] model(input int w, input logic [15:0] poly,
                                          input logic [15:0] init, input int n);
        logic [15:0] c, mask;
        logic        fb;
        mask = 16'((32'h1 << w) - 1);
        c = init & mask;
        for (int i = 0; i < n; i++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[w-1] ^ msg[i][b];
                c  = ((c << 1) ^ (fb ? poly : 16'h0)) & mask;
            end
        return c;
    endfunction

    task automatic load_digits();
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    endtask

    // Ends at the negedge after the edge that accepted the last beat
    task automatic send8(input int n, input logic chk, input logic [7:0] rf,
                         input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                repeat (g) begin
                    @(negedge clk);
                    in_valid = 0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                end
            end
            @(negedge clk);
            in_valid = 1;
            in_data  = msg[i];
            in_last  = (i == n - 1);
            chk_en   = chk;
            ref_crc  = rf;
        end
        @(negedge clk);
        in_valid = 0;
        in_last  = 0;
        chk_en   = 0;
    endtask

    task automatic expect_done(input string name, input logic [7:0] c,
                               input logic ok, input int cnt);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".ready"}, 32'(in_ready), 32'd0);
        check({name, ".crc"}, 32'(crc_out), 32'(c));
        check({name, ".ok"}, 32'(crc_ok), 32'(ok));
        check({name, ".cnt"}, 32'(beat_cnt), 32'(cnt));
        if (out_ready) begin
            @(negedge clk);
            check({name, ".drop"}, {31'd0, out_valid}, 32'd0);
            check({name, ".clr"}, {24'd0, crc_out}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] e8;
        logic [15:0] e16;

        vecs[0] = '{"b00", 1, 32'h00000000, 0, 8'h00, 8'h00, 0, 1};
        vecs[1] = '{"b01", 1, 32'h01000000, 0, 8'h00, 8'h07, 0, 1};
        vecs[2] = '{"b80", 1, 32'h80000000, 0, 8'h00, 8'h89, 0, 1};
        vecs[3] = '{"bff", 1, 32'hFF000000, 0, 8'h00, 8'hF3, 0, 1};
        vecs[4] = '{"b0100", 2, 32'h01000000, 0, 8'h00, 8'h15, 0, 2};
        vecs[5] = '{"chk_hit", 1, 32'h01000000, 1, 8'h07, 8'h07, 1, 1};
        vecs[6] = '{"chk_miss", 1, 32'h01000000, 1, 8'h06, 8'h07, 0, 1};
        vecs[7] = '{"chk_off", 1, 32'h01000000, 0, 8'h07, 8'h07, 0, 1};

        #12;
        check("rst.ready", {31'd0, in_ready}, 32'd0);
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("idle.ready", {31'd0, in_ready}, 32'd1);
        check("idle.cnt", {28'd0, beat_cnt}, 32'd0);
        check("idle.crc", {24'd0, crc_out}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 4; i++)
                msg[i] = vecs[v].bytes[31-8*i -: 8];
            send8(vecs[v].len, vecs[v].chk, vecs[v].rf, 0);
            expect_done(vecs[v].name, vecs[v].exp_crc, vecs[v].exp_ok,
                        vecs[v].exp_cnt);
        end

        load_digits();
        send8(9, 0, 8'h00, 0);
        expect_done("digits", 8'hF4, 0, 9);
        send8(9, 1, 8'hF4, 0);
        expect_done("digits_ok", 8'hF4, 1, 9);
        send8(9, 1, 8'hF5, 0);
        expect_done("digits_bad", 8'hF4, 0, 9);
        send8(9, 0, 8'hF4, 0);
        expect_done("digits_nochk", 8'hF4, 0, 9);
        send8(9, 0, 8'h00, 1);
        expect_done("gaps", 8'hF4, 0, 9);

        // 20 beats: counter saturates at 15
        for (int i = 0; i < 20; i++) msg[i] = 8'(i * 7 + 3);
        e8 = 8'(model(8, 16'h07, 16'h0, 20));
        send8(20, 0, 8'h00, 0);
        expect_done("sat", e8, 0, 15);

        // Result held under backpressure, input blocked
        load_digits();
        out_ready = 0;
        send8(9, 0, 8'h00, 0);
        in_valid = 1;
        in_data  = 8'hAA;
        in_last  = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp.ready", {31'd0, in_ready}, 32'd0);
            check("bp.valid", {31'd0, out_valid}, 32'd1);
            check("bp.crc", {24'd0, crc_out}, 32'hF4);
            check("bp.cnt", {28'd0, beat_cnt}, 32'd9);
        end
        in_valid = 0;
        in_last  = 0;
        out_ready = 1;
        @(negedge clk);
        check("bp.release", {31'd0, out_valid}, 32'd0);
        check("bp.idle_cnt", {28'd0, beat_cnt}, 32'd0);

        // Abort after 4 beats, with a beat presented during clr
        send8(4, 0, 8'h00, 0);
        in_valid = 1;
        in_data  = 8'h55;
        in_last  = 1;
        clr = 1;
        @(negedge clk);
        clr = 0;
        in_valid = 0;
        in_last  = 0;
        check("clr.valid", {31'd0, out_valid}, 32'd0);
        check("clr.cnt", {28'd0, beat_cnt}, 32'd0);
        send8(9, 0, 8'h00, 0);
        expect_done("after_clr", 8'hF4, 0, 9);

        // clr drops a pending result
        out_ready = 0;
        send8(9, 0, 8'h00, 0);
        clr = 1;
        @(negedge clk);
        clr = 0;
        check("clr_done.valid", {31'd0, out_valid}, 32'd0);
        check("clr_done.crc", {24'd0, crc_out}, 32'd0);
        out_ready = 1;

        // Async reset mid-message
        send8(4, 0, 8'h00, 0);
        #2;
        rst_n = 0;
        #1;
        check("arst.ready", {31'd0, in_ready}, 32'd0);
        check("arst.valid", {31'd0, out_valid}, 32'd0);
        check("arst.cnt", {28'd0, beat_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("arst.rel", {31'd0, in_ready}, 32'd1);
        send8(9, 0, 8'h00, 0);
        expect_done("after_rst", 8'hF4, 0, 9);

        // Async reset with a result pending
        out_ready = 0;
        send8(9, 0, 8'h00, 0);
        #2;
        rst_n = 0;
        #1;
        check("arst_done.valid", {31'd0, out_valid}, 32'd0);
        check("arst_done.crc", {24'd0, crc_out}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;

        // CRC-16, 8-bit beats
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a_valid = 1;
            a_data  = msg[i];
            a_last  = (i == 8);
        end
        @(negedge clk);
        a_valid = 0;
        a_last  = 0;
        check("c16.valid", {31'd0, a_ovalid}, 32'd1);
        check("c16.crc", {16'd0, a_crc}, 32'h29B1);
        check("c16.cnt", {16'd0, a_cnt}, 32'd9);

        // "12345678" at both beat widths must agree with the model
        e16 = model(16, 16'h1021, 16'hFFFF, 8);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_valid = 1;
            a_data  = msg[i];
            a_last  = (i == 7);
        end
        @(negedge clk);
        a_valid = 0;
        a_last  = 0;
        check("c16b8.crc", {16'd0, a_crc}, {16'd0, e16});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_valid = 1;
            b_data  = {msg[2*i], msg[2*i+1]};
            b_last  = (i == 3);
        end
        @(negedge clk);
        b_valid = 0;
        b_last  = 0;
        check("c16w.valid", {31'd0, b_ovalid}, 32'd1);
        check("c16w.crc", {16'd0, b_crc}, {16'd0, e16});
        check("c16w.cnt", {16'd0, b_cnt}, 32'd4);
        @(negedge clk);
        check("c16w.drop", {31'd0, b_ovalid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
